// File: rtl/letter_scheduler_if.sv
// Bundle between the letter scheduler and its generator, keyboard and renderer peers.
// The slave side is the scheduler; the master side drives game control, generator and keys.
interface letter_scheduler_if;
  logic        game_en;
  logic        frame_tick;
  logic [7:0]  gen_ch;
  logic [2:0]  gen_speed;
  logic [8:0]  gen_x;
  logic [9:0]  gen_y;
  logic        key_valid;
  logic [7:0]  key_ch;
  logic [3:0]  slot_valid;
  logic [31:0] slot_ch;
  logic [35:0] slot_x;
  logic [39:0] slot_y;
  logic        hit_pulse;
  logic        miss_pulse;
  logic [15:0] score;
  logic [7:0]  misses;

  modport master (
    output game_en, frame_tick, gen_ch, gen_speed, gen_x, gen_y, key_valid, key_ch,
    input  slot_valid, slot_ch, slot_x, slot_y, hit_pulse, miss_pulse, score, misses
  );

  modport slave (
    input  game_en, frame_tick, gen_ch, gen_speed, gen_x, gen_y, key_valid, key_ch,
    output slot_valid, slot_ch, slot_x, slot_y, hit_pulse, miss_pulse, score, misses
  );
endinterface

// File: rtl/letter_scheduler.sv
// Four-slot falling-letter scheduler: per-frame move/miss sweep, interval spawn,
// and keyboard hit matching (highest row wins) with score/miss counters.
module letter_scheduler #(
  parameter int SPAWN_INTERVAL = 60,
  parameter int BOTTOM         = 464
) (
  input  logic               clk,
  input  logic               rst,
  letter_scheduler_if.slave  bus
);
  localparam int CW = $clog2(SPAWN_INTERVAL + 1);

  typedef enum logic [2:0] {IDLE, MOVE0, MOVE1, MOVE2, MOVE3, SPAWN} state_t;
  state_t state_q, state_d;

  logic [3:0]        valid_q, valid_d;
  logic [3:0][7:0]   ch_q, ch_d;
  logic [3:0][8:0]   x_q, x_d;
  logic [3:0][9:0]   y_q, y_d;
  logic [3:0][2:0]   spd_q, spd_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic              pend_vld_q, pend_vld_d;
  logic [7:0]        pend_ch_q, pend_ch_d;
  logic              hit_q, hit_d, miss_q, miss_d;
  logic [15:0]       score_q, score_d;
  logic [7:0]        misses_q, misses_d;

  logic [7:0] key_use;
  logic       found, free_found;
  logic [1:0] win, free_idx, mv_idx;
  logic [8:0] best_x;
  logic [9:0] nx;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.game_en && bus.frame_tick) state_d = MOVE0;
      MOVE0:   state_d = MOVE1;
      MOVE1:   state_d = MOVE2;
      MOVE2:   state_d = MOVE3;
      MOVE3:   state_d = SPAWN;
      SPAWN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d    = valid_q;
    ch_d       = ch_q;
    x_d        = x_q;
    y_d        = y_q;
    spd_d      = spd_q;
    cnt_d      = cnt_q;
    cnt_inc    = cnt_q;
    pend_vld_d = pend_vld_q;
    pend_ch_d  = pend_ch_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    score_d    = score_q;
    misses_d   = misses_q;
    found      = 1'b0;
    win        = '0;
    best_x     = '0;
    free_found = 1'b0;
    free_idx   = '0;
    mv_idx     = 2'(3'(state_q) - 3'd1);
    nx         = '0;
    key_use    = bus.key_valid ? bus.key_ch : pend_ch_q;

    case (state_q)
      IDLE: if (bus.game_en) begin
        // A live key beats the pending one; either way pending is spent here.
        pend_vld_d = 1'b0;
        if (bus.key_valid || pend_vld_q) begin
          for (int i = 0; i < 4; i++)
            if (valid_q[i] && ch_q[i] == key_use && (!found || x_q[i] > best_x)) begin
              found  = 1'b1;
              win    = 2'(i);
              best_x = x_q[i];
            end
          if (found) begin
            valid_d[win] = 1'b0;
            hit_d        = 1'b1;
            if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
          end
        end
      end
      MOVE0, MOVE1, MOVE2, MOVE3: begin
        nx = {1'b0, x_q[mv_idx]} + {7'd0, spd_q[mv_idx]};
        if (valid_q[mv_idx]) begin
          if (nx >= 10'(BOTTOM)) begin
            valid_d[mv_idx] = 1'b0;
            miss_d          = 1'b1;
            if (misses_q != 8'hFF) misses_d = misses_q + 8'd1;
          end else begin
            x_d[mv_idx] = nx[8:0];
          end
        end
      end
      SPAWN: begin
        cnt_inc = (cnt_q >= CW'(SPAWN_INTERVAL)) ? cnt_q : cnt_q + 1'b1;
        cnt_d   = cnt_inc;
        for (int i = 3; i >= 0; i--)
          if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = 2'(i);
          end
        if (cnt_inc >= CW'(SPAWN_INTERVAL) && free_found) begin
          valid_d[free_idx] = 1'b1;
          ch_d[free_idx]    = bus.gen_ch;
          x_d[free_idx]     = bus.gen_x;
          y_d[free_idx]     = bus.gen_y;
          spd_d[free_idx]   = bus.gen_speed;
          cnt_d             = '0;
        end
      end
      default: ;
    endcase

    // Keys that arrive mid-sweep wait for the next IDLE cycle; newest wins.
    if (state_q != IDLE && bus.game_en && bus.key_valid) begin
      pend_vld_d = 1'b1;
      pend_ch_d  = bus.key_ch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      ch_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      spd_q      <= '0;
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_ch_q  <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      score_q    <= '0;
      misses_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      ch_q       <= ch_d;
      x_q        <= x_d;
      y_q        <= y_d;
      spd_q      <= spd_d;
      cnt_q      <= cnt_d;
      pend_vld_q <= pend_vld_d;
      pend_ch_q  <= pend_ch_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      score_q    <= score_d;
      misses_q   <= misses_d;
    end
  end

  assign bus.slot_valid = valid_q;
  assign bus.slot_ch    = ch_q;
  assign bus.slot_x     = x_q;
  assign bus.slot_y     = y_q;
  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;
  assign bus.score      = score_q;
  assign bus.misses     = misses_q;
endmodule
